fifo_stream_adapter: RTL and testbench
======================================

# fifo_stream_adapter

Read-side adapter placed directly downstream of the team's synchronous FIFO. It drives the FIFO's `r_en` and absorbs the FIFO's one-cycle registered read latency. It re-presents the data as a valid/ready stream with fully registered outputs, sustains one word per cycle, and keeps a wrapping count of delivered words. It also provides a synchronous flush.

## Interface
Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream data
- COUNT_WIDTH, 16, width of delivered-word counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fifo_empty  in  1  FIFO empty flag
- fifo_r_en  out  1  FIFO read enable; the FIFO pops when fifo_r_en && !fifo_empty
- fifo_data  in  DATA_WIDTH  FIFO registered read data, valid the cycle after a pop
- flush  in  1  synchronous clear of buffered and in-flight words
- m_valid  out  1  stream word available
- m_ready  in  1  downstream accepts
- m_data  out  DATA_WIDTH  stream word
- xfer_count  out  COUNT_WIDTH  number of m_valid && m_ready handshakes, mod 2^COUNT_WIDTH

## Operation
- State:
  - 2-entry buffer buf0 (head) and buf1
  - count, range 0..2
  - inflight bit, set when a pop was issued in the previous cycle
- Definitions: pop = m_valid && m_ready; arrive = inflight && !flush.
- Read issue:
  - fifo_r_en = rst_n && !flush && !fifo_empty && ((count + inflight < 2) || pop)
  - Guarantees count + inflight never exceeds 2. No word is ever dropped without a flush.
- inflight_next = fifo_r_en && !fifo_empty.
- Buffer update, when not flushing:
  - count_next = count + arrive - pop
  - On pop, buf1 shifts into buf0.
  - The arriving fifo_data is written to slot (count - pop), so ordering is strictly FIFO.
- m_valid = (count != 0); m_data = buf0. Both are driven directly from registers.
- flush:
  - count <= 0 and inflight <= 0. fifo_r_en = 0 during the flush cycle.
  - A word popped in the cycle before the flush arrives during the flush cycle and is discarded. That word is lost by design.
  - A handshake in the flush cycle is still counted in xfer_count.
- xfer_count increments on every pop and wraps from all-ones to 0. It is cleared only by reset.
- The downstream may hold m_ready high or low arbitrarily. m_data and m_valid stay stable while m_valid && !m_ready.

## Timing
- Reset (async assert):
  - m_valid = 0, m_data = 0, xfer_count = 0, count = 0, inflight = 0, buf0/buf1 = 0
  - fifo_r_en = 0 while rst_n is low
- Reset release: normal operation from the first clk edge with rst_n high. No synchronizer is inside the block.
- Reset asserted mid-transfer: all buffered and in-flight words are lost. The FIFO is expected to be reset together with this block.
- Latency:
  - FIFO non-empty in cycle N → fifo_r_en high in N → fifo_data valid in N+1 → m_valid high in N+2.
- Throughput: with m_ready held high and FIFO non-empty, one word per cycle indefinitely. Steady state is count = 1, inflight = 1.
- Backpressure: with m_ready low, at most 2 words are held, and fifo_r_en drops once count + inflight = 2. The pop-bypass term reissues a read in the same cycle m_ready returns, so there is no bubble.
- Simultaneous arrive and pop at count = 2: not reachable, because the issue rule forbids it. An assertion is required in the bench.
- Empty FIFO: fifo_r_en stays 0. The buffer drains normally.

## Test plan
- Reset and fill: reset, then push 0x11, 0x22, 0x33 into the FIFO with m_ready = 1 → first m_valid exactly 2 cycles after the first fifo_r_en; words 0x11, 0x22, 0x33 on consecutive cycles; xfer_count = 3.
- Backpressure: 5 words in the FIFO with m_ready = 0 → exactly 2 pops, m_valid = 1, m_data = first word held stable. Then raise m_ready → all 5 words delivered in order with no gap; xfer_count = 5.
- Random m_ready (50%) over 1000 words → output order equals input order; count + inflight ≤ 2 every cycle; no duplicated or missing words.
- Flush with a word in flight: assert flush the cycle after a pop → m_valid = 0 the next cycle. The in-flight word is never presented. Subsequent words stream normally.
- Counter wrap with COUNT_WIDTH = 4: 17 handshakes → xfer_count = 1.
- Async reset mid-stream with count = 2 → m_valid, m_data, xfer_count, and fifo_r_en are 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/fifo_stream_adapter.sv
// Read-side adapter for the synchronous FIFO: issues r_en, absorbs the one-cycle
// read latency and re-presents words as a registered valid/ready stream.
module fifo_stream_adapter #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_r_en,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  localparam logic [COUNT_WIDTH-1:0] XFER_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]  buf0;
  logic [DATA_WIDTH-1:0]  buf1;
  logic [1:0]             count;
  logic                   inflight;
  logic                   valid_q;
  logic [COUNT_WIDTH-1:0] xfer_q;

  logic       pop;
  logic       arrive;
  logic       room;
  logic       issue;
  logic [1:0] count_next;
  logic [1:0] slot;

  assign pop    = valid_q && m_ready;
  assign arrive = inflight && !flush;

  // The pop term lets a read be reissued in the same cycle a full buffer drains,
  // so backpressure release costs no bubble.
  assign room      = (({1'b0, count} + {2'b00, inflight}) < 3'd2);
  assign fifo_r_en = rst_n && !flush && !fifo_empty && (room || pop);
  assign issue     = fifo_r_en && !fifo_empty;

  always_comb begin
    count_next = count + {1'b0, arrive} - {1'b0, pop};
    slot       = count - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0     <= '0;
      buf1     <= '0;
      count    <= 2'd0;
      inflight <= 1'b0;
      valid_q  <= 1'b0;
      xfer_q   <= '0;
    end else begin
      if (pop)
        xfer_q <= xfer_q + XFER_ONE;
      inflight <= issue;
      if (flush) begin
        count   <= 2'd0;
        valid_q <= 1'b0;
      end else begin
        count   <= count_next;
        valid_q <= (count_next != 2'd0);
        if (pop)
          buf0 <= buf1;
        // The arriving word lands behind whatever survives this cycle's pop.
        if (arrive && (slot == 2'd0))
          buf0 <= fifo_data;
        if (arrive && (slot == 2'd1))
          buf1 <= fifo_data;
      end
    end
  end

  assign m_valid    = valid_q;
  assign m_data     = buf0;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Self-checking bench for fifo_stream_adapter: FIFO model, order scoreboard and
// directed scenarios with hand-computed expectations.
module tb_fifo_stream_adapter;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_data;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] xfer_count;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  logic [DW-1:0] mem [0:2047];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic [DW-1:0] exp_q [$];
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  fifo_stream_adapter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // FIFO with one-cycle registered read data
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data <= '0;
    end else if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Scoreboard: words leave the FIFO in order and must be delivered in that order
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++;
          $display("[TB] FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", m_valid, m_data, prev_data);
        end
      end
      checks++;
      assert (!(dut.count == 2'd2 && dut.inflight && m_valid && m_ready && !flush))
      else begin
        errors++;
        $display("[TB] FAIL arrive_pop_full: arrive and pop together at count=2");
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL order: got unexpected word %h, required none", m_data);
        end else begin
          if (m_data !== exp_q[0]) begin
            errors++;
            $display("[TB] FAIL order: got %h, required %h", m_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        delivered++;
      end
      if (flush)
        exp_q.delete();
      if (fifo_r_en && !fifo_empty)
        exp_q.push_back(mem[rd_ptr]);
      checks++;
      if (exp_q.size() > 2) begin
        errors++;
        $display("[TB] FAIL occupancy: count+inflight=%0d, required <= 2", exp_q.size());
      end
      prev_hold = m_valid && !m_ready && !flush;
      prev_data = m_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    tick();
    wr_ptr = rd_ptr;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    push(8'hAA);
    #3;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h, required 00", m_data); end
    checks++; if (xfer_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d, required 0", xfer_count); end
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_en: got %b, required 0", fifo_r_en); end
    do_reset();
  endtask

  task automatic test_fill;
    do_reset();
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    #1;
    checks++; if (fifo_r_en !== 1'b1) begin errors++; $display("[TB] FAIL fill_r_en: got %b, required 1", fifo_r_en); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_latency1: valid=%b, required 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin errors++; $display("[TB] FAIL fill_w0: valid=%b data=%h, required 1/11", m_valid, m_data); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h22) begin errors++; $display("[TB] FAIL fill_w1: valid=%b data=%h, required 1/22", m_valid, m_data); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h33) begin errors++; $display("[TB] FAIL fill_w2: valid=%b data=%h, required 1/33", m_valid, m_data); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_drain: valid=%b, required 0", m_valid); end
    checks++; if (xfer_count !== 4'd3) begin errors++; $display("[TB] FAIL fill_count: got %0d, required 3", xfer_count); end
  endtask

  task automatic test_backpressure;
    int rd0;
    logic [DW-1:0] e;
    do_reset();
    rd0 = rd_ptr;
    for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
    repeat (6) tick();
    checks++; if (rd_ptr - rd0 != 2) begin errors++; $display("[TB] FAIL bp_pops: got %0d, required 2", rd_ptr - rd0); end
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_r_en: got %b, required 0", fifo_r_en); end
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h51) begin errors++; $display("[TB] FAIL bp_hold: valid=%b data=%h, required 1/51", m_valid, m_data); end
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = 8'h51 + 8'(k);
      checks++;
      if (m_valid !== 1'b1 || m_data !== e) begin errors++; $display("[TB] FAIL bp_release: valid=%b data=%h, required 1/%h", m_valid, m_data, e); end
    end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: valid=%b, required 0", m_valid); end
    checks++; if (xfer_count !== 4'd5) begin errors++; $display("[TB] FAIL bp_count: got %0d, required 5", xfer_count); end
  endtask

  task automatic test_flush;
    do_reset();
    m_ready = 1'b1;
    push(8'h61); push(8'h62);
    tick();
    flush = 1'b1;
    #1;
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("[TB] FAIL flush_r_en: got %b, required 0", fifo_r_en); end
    tick();
    flush = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b, required 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_discard: got %b, required 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h62) begin errors++; $display("[TB] FAIL flush_resume: valid=%b data=%h, required 1/62", m_valid, m_data); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drain: got %b, required 0", m_valid); end
    checks++; if (xfer_count !== 4'd1) begin errors++; $display("[TB] FAIL flush_count: got %0d, required 1", xfer_count); end
  endtask

  task automatic test_wrap;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(8'h70 + 8'(i));
    repeat (25) tick();
    checks++; if (xfer_count !== 4'd1) begin errors++; $display("[TB] FAIL wrap_count: got %0d, required 1", xfer_count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_drain: got %b, required 0", m_valid); end
  endtask

  task automatic test_random;
    int start;
    int cyc;
    do_reset();
    start = delivered;
    for (int i = 0; i < 1000; i++) push(8'($urandom_range(0, 255)));
    cyc = 0;
    while (cyc < 6000 && delivered - start < 1000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    checks++; if (delivered - start != 1000) begin errors++; $display("[TB] FAIL random_delivered: got %0d, required 1000", delivered - start); end
    checks++; if (xfer_count !== 4'd8) begin errors++; $display("[TB] FAIL random_count: got %0d, required 8", xfer_count); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL random_drain: got %b, required 0", m_valid); end
  endtask

  task automatic test_async_reset;
    do_reset();
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    repeat (5) tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hA1) begin errors++; $display("[TB] FAIL ar_fill: valid=%b data=%h, required 1/a1", m_valid, m_data); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hA2 || xfer_count !== 4'd1) begin errors++; $display("[TB] FAIL ar_pre: valid=%b data=%h count=%0d, required 1/a2/1", m_valid, m_data, xfer_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid: got %b, required 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL ar_data: got %h, required 00", m_data); end
    checks++; if (xfer_count !== 4'd0) begin errors++; $display("[TB] FAIL ar_count: got %0d, required 0", xfer_count); end
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("[TB] FAIL ar_r_en: got %b, required 0", fifo_r_en); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_flush();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
